// File: rtl/seq_circuit_driver_pkg.sv
// Shared types and constants for the mod-4 up/down circuit driver.
package seq_circuit_driver_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } drv_state_e;

  localparam logic       DIR_UP   = 1'b0;
  localparam logic       DIR_DOWN = 1'b1;
  localparam logic [1:0] Y_STATE  = 2'b11;

  // One step of the downstream circuit: A=0 counts up, A=1 counts down.
  function automatic logic [1:0] step_state(input logic [1:0] s, input logic dir);
    return (dir == DIR_DOWN) ? s - 2'd1 : s + 2'd1;
  endfunction

endpackage

// File: rtl/seq_mirror_model.sv
// Mirror of the downstream 2-bit mod-4 up/down circuit, advanced by the same A
// on every clock so its state and Y prediction track the real circuit.
module seq_mirror_model
  import seq_circuit_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  output logic [1:0] mirror_state,
  output logic       y_pred
);

  always_ff @(posedge clk) begin
    if (rst) begin
      mirror_state <= 2'd0;
    end else begin
      mirror_state <= step_state(mirror_state, a);
    end
  end

  assign y_pred = (mirror_state == Y_STATE);

endmodule

// File: rtl/seq_circuit_driver.sv
// Drives A into the mod-4 up/down circuit to execute step-count move commands,
// holds position between moves by alternating A, and flags Y mismatches.
//
// state | meaning
// IDLE  | A toggles, net zero motion around home H; ready when A=1
// MOVE  | A held at command direction, cnt down-counts remaining steps
module seq_circuit_driver
  import seq_circuit_driver_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  output logic             A,
  input  logic             Y_obs,
  output logic [1:0]       mirror_state,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  drv_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             y_pred;
  logic             mismatch;

  seq_mirror_model u_mirror (
    .clk          (clk),
    .rst          (rst),
    .a            (A),
    .mirror_state (mirror_state),
    .y_pred       (y_pred)
  );

  // Only offer a command when the coming edge brings the circuit back to H.
  assign cmd_ready = (state == IDLE) && A;
  assign mismatch  = (Y_obs != y_pred);

  always_comb begin
    state_nxt = state;
    a_nxt     = A;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        a_nxt = ~A;
        if (cmd_valid && cmd_ready) begin
          if (cmd_steps != '0) begin
            state_nxt = MOVE;
            a_nxt     = cmd_dir;
            cnt_nxt   = cmd_steps;
            busy_nxt  = 1'b1;
          end else begin
            a_nxt    = DIR_UP;
            done_nxt = 1'b1;
          end
        end
      end
      MOVE: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          a_nxt     = DIR_UP;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        a_nxt     = DIR_UP;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      A     <= DIR_UP;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      A     <= a_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // A fresh mismatch beats a simultaneous clear so no error is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (mismatch) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_circuit_driver.sv
// Bench for seq_circuit_driver: ideal downstream circuit with Y fault injection,
// transaction-level model of home position and per-cycle expectations.
module tb_seq_circuit_driver;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic             A;
  logic             Y_obs;
  logic [1:0]       mirror_state;
  logic             busy;
  logic             done;
  logic             err;
  logic             err_clr = 1'b0;

  logic [1:0] ds_state;
  logic       force_y0 = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   h        = 0;
  int   ph       = 0;
  logic err_exp  = 1'b0;
  bit   garbage_en = 1'b0;

  seq_circuit_driver #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dir      (cmd_dir),
    .cmd_steps    (cmd_steps),
    .A            (A),
    .Y_obs        (Y_obs),
    .mirror_state (mirror_state),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  // Ideal downstream circuit sharing clock and reset with the driver.
  always_ff @(posedge clk) begin
    if (rst) ds_state <= 2'd0;
    else     ds_state <= A ? ds_state - 2'd1 : ds_state + 2'd1;
  end

  assign Y_obs = force_y0 ? 1'b0 : (ds_state == 2'b11);

  function automatic int pos(input int hh, input bit dir, input int k);
    return dir ? (((hh - k) % 4) + 4) % 4 : (hh + k) % 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_cycle(input int m, input int a, input int rdy, input int bsy, input int dn);
    chk("mirror_state", 32'(mirror_state), 32'(m));
    chk("A", 32'(A), 32'(a));
    chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
    chk("busy", 32'(busy), 32'(bsy));
    chk("done", 32'(done), 32'(dn));
    chk("err", 32'(err), 32'(err_exp));
  endtask

  task automatic drive_garbage(input bit allow);
    cmd_valid = (allow && garbage_en) ? 1'($urandom_range(0, 1)) : 1'b0;
    cmd_dir   = 1'($urandom);
    cmd_steps = CNT_W'($urandom);
  endtask

  task automatic idle_step();
    drive_garbage(ph == 0);
    chk_cycle((h + ph) % 4, ph, ph, 0, 0);
    @(negedge clk);
    ph ^= 1;
  endtask

  task automatic goto_mirror3();
    for (int k = 0; k < 4 && ((h + ph) % 4) != 3; k++) idle_step();
  endtask

  task automatic send_cmd(input bit dir, input int n, input int abort_at);
    int hn;
    if (ph == 0) idle_step();
    chk_cycle((h + 1) % 4, 1, 1, 0, 0);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = CNT_W'(n);
    @(negedge clk);
    hn = pos(h, dir, n);
    for (int j = 0; j <= n + 1; j++) begin
      drive_garbage(j <= n);
      if (j < n)       chk_cycle(pos(h, dir, j), dir, 0, 1, 0);
      else if (j == n) chk_cycle(hn, 0, 0, 0, 1);
      else             chk_cycle((hn + 1) % 4, 1, 1, 0, 0);
      if (j == abort_at) begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        err_exp = 1'b0;
        h  = 0;
        ph = 0;
        chk_cycle(0, 0, 0, 0, 0);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    h  = hn;
    ph = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cycle(0, 0, 0, 0, 0);
    rst = 1'b0;
    h = 0;
    ph = 0;

    repeat (8) idle_step();

    send_cmd(1'b0, 3, -1);
    repeat (4) idle_step();
    send_cmd(1'b0, 1, -1);
    send_cmd(1'b1, 5, -1);
    repeat (3) idle_step();
    send_cmd(1'b0, 0, -1);
    repeat (3) idle_step();

    goto_mirror3();
    force_y0 = 1'b1;
    idle_step();
    force_y0 = 1'b0;
    err_exp = 1'b1;
    repeat (3) idle_step();
    goto_mirror3();
    force_y0 = 1'b1;
    err_clr  = 1'b1;
    idle_step();
    force_y0 = 1'b0;
    err_clr  = 1'b0;
    idle_step();
    err_clr = 1'b1;
    idle_step();
    err_clr = 1'b0;
    err_exp = 1'b0;
    repeat (3) idle_step();

    send_cmd(1'b0, 6, 2);
    repeat (6) idle_step();

    garbage_en = 1'b1;
    send_cmd(1'b1, 255, -1);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 5)) idle_step();
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 9));
      send_cmd(1'($urandom_range(0, 1)), n, -1);
    end
    repeat (4) idle_step();
    cmd_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
